// File: rtl/ps2_packet_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_packet_tx
// Function : Builds 3-byte PS/2 mouse packets from btn/dx/dy and streams them
//            out one byte at a time over a valid/ready byte interface.
// Option   : define PS2_TX_SAT_EN to clamp out-of-range motion and set the
//            overflow bits; otherwise motion is truncated to 9 bits.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_packet_tx #(
   parameter int GAP_CYCLES = 0,
   parameter int MW         = 10
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          pkt_valid,
   output logic          pkt_ready,
   input  logic [2:0]    btn,
   input  logic [MW-1:0] dx,
   input  logic [MW-1:0] dy,
   output logic [7:0]    out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          done,
   output logic          busy,
   output logic [15:0]   pkt_count
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SEND1 = 3'd1;
   localparam logic [2:0] S_GAP1  = 3'd2;
   localparam logic [2:0] S_SEND2 = 3'd3;
   localparam logic [2:0] S_GAP2  = 3'd4;
   localparam logic [2:0] S_SEND3 = 3'd5;

   localparam logic       c_has_gap  = (GAP_CYCLES > 0);
   localparam logic [7:0] c_gap_load = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

   logic [2:0]  r_state;
   logic [2:0]  w_state_nxt;
   logic [23:0] r_pkt;
   logic [7:0]  r_last;
   logic [7:0]  r_gap_cnt;
   logic        r_done;
   logic [15:0] r_pkt_count;

   logic [8:0]  w_x9;
   logic [8:0]  w_y9;
   logic        w_xovf;
   logic        w_yovf;
   logic [23:0] w_enc;
   logic        w_accept;
   logic        w_byte_hs;
   logic        w_last_hs;
   logic        w_gap_enter;

   // ------------------------------------------------------------------------
   // Motion encoding into 9-bit two's complement plus overflow flag
   // ------------------------------------------------------------------------
`ifdef PS2_TX_SAT_EN
   localparam logic signed [MW-1:0] c_pos_lim = MW'(255);
   localparam logic signed [MW-1:0] c_neg_lim = MW'(-256);

   always_comb begin
      w_x9   = dx[8:0];
      w_y9   = dy[8:0];
      w_xovf = 1'b0;
      w_yovf = 1'b0;
      if ($signed(dx) > c_pos_lim) begin
         w_x9   = 9'h0FF;
         w_xovf = 1'b1;
      end else if ($signed(dx) < c_neg_lim) begin
         w_x9   = 9'h100;
         w_xovf = 1'b1;
      end
      if ($signed(dy) > c_pos_lim) begin
         w_y9   = 9'h0FF;
         w_yovf = 1'b1;
      end else if ($signed(dy) < c_neg_lim) begin
         w_y9   = 9'h100;
         w_yovf = 1'b1;
      end
   end
`else
   logic w_unused_hi;

   // Upper motion bits are discarded by the truncating encoder
   assign w_unused_hi = ^{dx, dy};

   always_comb begin
      w_x9   = dx[8:0];
      w_y9   = dy[8:0];
      w_xovf = 1'b0;
      w_yovf = 1'b0;
   end
`endif

   assign w_enc = {w_yovf, w_xovf, w_y9[8], w_x9[8], 1'b1, btn,
                   w_x9[7:0], w_y9[7:0]};

   assign w_accept    = (r_state == S_IDLE) && pkt_valid;
   assign w_byte_hs   = out_valid && out_ready;
   assign w_last_hs   = (r_state == S_SEND3) && out_ready;
   assign w_gap_enter = c_has_gap && out_ready &&
                        ((r_state == S_SEND1) || (r_state == S_SEND2));

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (pkt_valid) w_state_nxt = S_SEND1;
         end
         S_SEND1: begin
            if (out_ready) w_state_nxt = c_has_gap ? S_GAP1 : S_SEND2;
         end
         S_GAP1: begin
            if (r_gap_cnt == 8'd0) w_state_nxt = S_SEND2;
         end
         S_SEND2: begin
            if (out_ready) w_state_nxt = c_has_gap ? S_GAP2 : S_SEND3;
         end
         S_GAP2: begin
            if (r_gap_cnt == 8'd0) w_state_nxt = S_SEND3;
         end
         S_SEND3: begin
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs (out_data falls back to the last sent byte when not valid)
   // ------------------------------------------------------------------------
   always_comb begin
      pkt_ready = (r_state == S_IDLE);
      busy      = (r_state != S_IDLE);
      out_valid = 1'b0;
      out_data  = r_last;
      case (r_state)
         S_SEND1: begin
            out_valid = 1'b1;
            out_data  = r_pkt[23:16];
         end
         S_SEND2: begin
            out_valid = 1'b1;
            out_data  = r_pkt[15:8];
         end
         S_SEND3: begin
            out_valid = 1'b1;
            out_data  = r_pkt[7:0];
         end
         default: begin
            out_valid = 1'b0;
            out_data  = r_last;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pkt       <= 24'd0;
         r_last      <= 8'd0;
         r_gap_cnt   <= 8'd0;
         r_done      <= 1'b0;
         r_pkt_count <= 16'd0;
      end else begin
         r_done <= w_last_hs;
         if (w_accept) begin
            r_pkt <= w_enc;
         end
         if (w_byte_hs) begin
            r_last <= out_data;
         end
         if (w_gap_enter) begin
            r_gap_cnt <= c_gap_load;
         end else if (((r_state == S_GAP1) || (r_state == S_GAP2)) &&
                      (r_gap_cnt != 8'd0)) begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
         end
         if (w_last_hs) begin
            r_pkt_count <= r_pkt_count + 16'd1;
         end
      end
   end

   assign done      = r_done;
   assign pkt_count = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_ps2_packet_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_packet_tx
// Function : Self-checking bench for ps2_packet_tx; one instance with no gap,
//            one with GAP_CYCLES=3, checked against a behavioural packet model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_packet_tx;

   localparam int MW = 10;

   logic          clk = 1'b0;
   logic          reset_n   [2];
   logic          pkt_valid [2];
   logic          pkt_ready [2];
   logic [2:0]    btn       [2];
   logic [MW-1:0] dx        [2];
   logic [MW-1:0] dy        [2];
   logic [7:0]    out_data  [2];
   logic          out_valid [2];
   logic          out_ready [2];
   logic          done      [2];
   logic          busy      [2];
   logic [15:0]   pkt_count [2];

   int total = 0;
   int bad   = 0;
   int exp_count [2];

   always #5 clk = ~clk;

   ps2_packet_tx #(.GAP_CYCLES(0), .MW(MW)) u_dut0 (
      .clk(clk), .reset_n(reset_n[0]), .pkt_valid(pkt_valid[0]),
      .pkt_ready(pkt_ready[0]), .btn(btn[0]), .dx(dx[0]), .dy(dy[0]),
      .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .done(done[0]), .busy(busy[0]), .pkt_count(pkt_count[0])
   );

   ps2_packet_tx #(.GAP_CYCLES(3), .MW(MW)) u_dut1 (
      .clk(clk), .reset_n(reset_n[1]), .pkt_valid(pkt_valid[1]),
      .pkt_ready(pkt_ready[1]), .btn(btn[1]), .dx(dx[1]), .dy(dy[1]),
      .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .done(done[1]), .busy(busy[1]), .pkt_count(pkt_count[1])
   );

   // Reference encoding from plain integer motion values
   function automatic logic [8:0] axis9(input int v, output logic ovf);
      int w;
      ovf = 1'b0;
`ifdef PS2_TX_SAT_EN
      if (v > 255) begin
         ovf = 1'b1;
         return 9'h0FF;
      end
      if (v < -256) begin
         ovf = 1'b1;
         return 9'h100;
      end
`endif
      w = ((v % 512) + 512) % 512;
      return 9'(w);
   endfunction

   function automatic logic [23:0] model_pkt(input logic [2:0] b, input int x, input int y);
      logic [8:0] xv;
      logic [8:0] yv;
      logic       xo;
      logic       yo;
      xv = axis9(x, xo);
      yv = axis9(y, yo);
      return {yo, xo, yv[8], xv[8], 1'b1, b, xv[7:0], yv[7:0]};
   endfunction

   // Drives one packet and records what the DUT emitted (no judgement here)
   task automatic xfer(input int u, input logic [2:0] b, input int x, input int y,
                       input int rpct, input bit keep,
                       output logic [7:0] got [3], output int gap [2], output int cyc,
                       output bit done_ok, output bit busy_ok, output bit hold_ok,
                       output bit tmo);
      int         n;
      bit         acc;
      bit         hs_acc;
      bit         hs_b;
      bit         prev_stall;
      logic [7:0] prev_d;
      logic [7:0] last;
      n = 0; acc = 0; cyc = 0; gap[0] = 0; gap[1] = 0;
      done_ok = 1; busy_ok = 1; hold_ok = 1; tmo = 1;
      prev_stall = 0; prev_d = 8'd0; last = 8'd0;
      got[0] = 8'd0; got[1] = 8'd0; got[2] = 8'd0;
      pkt_valid[u] = 1'b1;
      btn[u]       = b;
      dx[u]        = MW'(x);
      dy[u]        = MW'(y);
      out_ready[u] = ($urandom_range(0, 99) < rpct);
      for (int k = 0; k < 400; k++) begin
         hs_acc = !acc && pkt_ready[u];
         hs_b   = acc && out_valid[u] && out_ready[u];
         if (acc && done[u]) done_ok = 0;
         if (acc && !busy[u]) busy_ok = 0;
         if (prev_stall && (!out_valid[u] || out_data[u] !== prev_d)) hold_ok = 0;
         if (acc && !out_valid[u]) begin
            if (out_data[u] !== last) hold_ok = 0;
            if (n > 0 && n < 3) gap[n-1]++;
         end
         prev_stall = acc && out_valid[u] && !out_ready[u];
         prev_d     = out_data[u];
         if (hs_b) begin
            got[n] = out_data[u];
            last   = out_data[u];
            n++;
         end
         @(negedge clk);
         if (hs_acc) begin
            acc = 1;
            cyc = 1;
            if (!keep) pkt_valid[u] = 1'b0;
         end else if (acc) begin
            cyc++;
         end
         out_ready[u] = ($urandom_range(0, 99) < rpct);
         if (n == 3) begin
            if (done[u] !== 1'b1 || pkt_ready[u] !== 1'b1) done_ok = 0;
            tmo = 0;
            break;
         end
      end
      if (!keep) pkt_valid[u] = 1'b0;
   endtask

   task automatic test_reset;
      for (int u = 0; u < 2; u++) begin
         reset_n[u] = 1'b0; pkt_valid[u] = 1'b0; out_ready[u] = 1'b0;
         btn[u] = 3'd0; dx[u] = '0; dy[u] = '0; exp_count[u] = 0;
      end
      repeat (3) @(negedge clk);
      reset_n[0] = 1'b1; reset_n[1] = 1'b1;
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         total++; if (pkt_ready[u] !== 1'b1) begin bad++; $display("FAIL reset_pkt_ready dut%0d got %b want 1", u, pkt_ready[u]); end
         total++; if (out_valid[u] !== 1'b0) begin bad++; $display("FAIL reset_out_valid dut%0d got %b want 0", u, out_valid[u]); end
         total++; if (out_data[u] !== 8'h00) begin bad++; $display("FAIL reset_out_data dut%0d got %h want 00", u, out_data[u]); end
         total++; if (done[u] !== 1'b0) begin bad++; $display("FAIL reset_done dut%0d got %b want 0", u, done[u]); end
         total++; if (busy[u] !== 1'b0) begin bad++; $display("FAIL reset_busy dut%0d got %b want 0", u, busy[u]); end
         total++; if (pkt_count[u] !== 16'd0) begin bad++; $display("FAIL reset_pkt_count dut%0d got %0d want 0", u, pkt_count[u]); end
      end
   endtask

   task automatic test_basic;
      logic [7:0]  got [3];
      int          gap [2];
      int          cyc;
      bit          dk, bk, hk, tmo;
      logic [23:0] e;
      e = model_pkt(3'b001, 5, -3);
      xfer(0, 3'b001, 5, -3, 100, 0, got, gap, cyc, dk, bk, hk, tmo);
      exp_count[0]++;
      total++; if (tmo) begin bad++; $display("FAIL basic_timeout got timeout want completion"); end
      for (int i = 0; i < 3; i++) begin
         total++; if (got[i] !== e[23-8*i -: 8]) begin bad++; $display("FAIL basic_byte%0d got %h want %h", i+1, got[i], e[23-8*i -: 8]); end
      end
      total++; if (cyc !== 4) begin bad++; $display("FAIL basic_latency got %0d want 4", cyc); end
      total++; if (gap[0] !== 0 || gap[1] !== 0) begin bad++; $display("FAIL basic_gaps got %0d/%0d want 0/0", gap[0], gap[1]); end
      total++; if (!dk) begin bad++; $display("FAIL basic_done got misplaced pulse want one pulse after byte3"); end
      total++; if (!bk) begin bad++; $display("FAIL basic_busy got low want high during packet"); end
      total++; if (pkt_count[0] !== 16'(exp_count[0])) begin bad++; $display("FAIL basic_count got %0d want %0d", pkt_count[0], exp_count[0]); end
   endtask

   task automatic test_stall;
      logic [23:0] e;
      e = model_pkt(3'b001, 5, -3);
      pkt_valid[0] = 1'b1; btn[0] = 3'b001; dx[0] = MW'(5); dy[0] = MW'(-3); out_ready[0] = 1'b1;
      @(negedge clk);
      pkt_valid[0] = 1'b0;
      total++; if ({out_valid[0], out_data[0]} !== {1'b1, e[23:16]}) begin bad++; $display("FAIL stall_byte1 got %b/%h want 1/%h", out_valid[0], out_data[0], e[23:16]); end
      @(negedge clk);
      out_ready[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         total++;
         if ({out_valid[0], busy[0], out_data[0]} !== {1'b1, 1'b1, e[15:8]}) begin
            bad++; $display("FAIL stall_hold%0d got v=%b busy=%b %h want v=1 busy=1 %h", i, out_valid[0], busy[0], out_data[0], e[15:8]);
         end
         @(negedge clk);
      end
      out_ready[0] = 1'b1;
      total++; if ({out_valid[0], out_data[0]} !== {1'b1, e[15:8]}) begin bad++; $display("FAIL stall_resume got %b/%h want 1/%h", out_valid[0], out_data[0], e[15:8]); end
      @(negedge clk);
      total++; if ({out_valid[0], out_data[0]} !== {1'b1, e[7:0]}) begin bad++; $display("FAIL stall_byte3 got %b/%h want 1/%h", out_valid[0], out_data[0], e[7:0]); end
      @(negedge clk);
      exp_count[0]++;
      total++; if (done[0] !== 1'b1) begin bad++; $display("FAIL stall_done got %b want 1", done[0]); end
      total++; if (pkt_count[0] !== 16'(exp_count[0])) begin bad++; $display("FAIL stall_count got %0d want %0d", pkt_count[0], exp_count[0]); end
   endtask

   task automatic test_back_to_back;
      logic [7:0]  g1 [3];
      logic [7:0]  g2 [3];
      int          gap [2];
      int          c1, c2;
      bit          dk1, dk2, bk, hk, t1, t2;
      logic [23:0] e1, e2;
      logic [2:0]  b1, b2;
      int          x1, y1, x2, y2;
      b1 = 3'($urandom); b2 = 3'($urandom);
      x1 = int'($urandom_range(0, 1023)) - 512; y1 = int'($urandom_range(0, 1023)) - 512;
      x2 = int'($urandom_range(0, 1023)) - 512; y2 = int'($urandom_range(0, 1023)) - 512;
      e1 = model_pkt(b1, x1, y1);
      e2 = model_pkt(b2, x2, y2);
      xfer(0, b1, x1, y1, 100, 1, g1, gap, c1, dk1, bk, hk, t1);
      xfer(0, b2, x2, y2, 100, 0, g2, gap, c2, dk2, bk, hk, t2);
      exp_count[0] += 2;
      total++; if (t1 || t2) begin bad++; $display("FAIL b2b_timeout got timeout want completion"); end
      total++; if (c1 + c2 !== 8) begin bad++; $display("FAIL b2b_cycles got %0d want 8", c1 + c2); end
      total++; if ({g1[0], g1[1], g1[2]} !== e1) begin bad++; $display("FAIL b2b_pkt1 got %h%h%h want %h", g1[0], g1[1], g1[2], e1); end
      total++; if ({g2[0], g2[1], g2[2]} !== e2) begin bad++; $display("FAIL b2b_pkt2 got %h%h%h want %h", g2[0], g2[1], g2[2], e2); end
      total++; if (!dk1 || !dk2) begin bad++; $display("FAIL b2b_done got %b%b want 11", dk1, dk2); end
      total++; if (pkt_count[0] !== 16'(exp_count[0])) begin bad++; $display("FAIL b2b_count got %0d want %0d", pkt_count[0], exp_count[0]); end
   endtask

   task automatic test_gap;
      logic [7:0]  got [3];
      int          gap [2];
      int          cyc;
      bit          dk, bk, hk, tmo, idle_ok;
      logic [23:0] e;
      e = model_pkt(3'b110, -7, 42);
      xfer(1, 3'b110, -7, 42, 100, 0, got, gap, cyc, dk, bk, hk, tmo);
      exp_count[1]++;
      total++; if (tmo) begin bad++; $display("FAIL gap_timeout got timeout want completion"); end
      total++; if (gap[0] !== 3 || gap[1] !== 3) begin bad++; $display("FAIL gap_len got %0d/%0d want 3/3", gap[0], gap[1]); end
      total++; if ({got[0], got[1], got[2]} !== e) begin bad++; $display("FAIL gap_bytes got %h%h%h want %h", got[0], got[1], got[2], e); end
      total++; if (cyc !== 10) begin bad++; $display("FAIL gap_latency got %0d want 10", cyc); end
      total++; if (!hk) begin bad++; $display("FAIL gap_hold got changed want last byte held"); end
      total++; if (!dk || !bk) begin bad++; $display("FAIL gap_done_busy got done_ok=%b busy_ok=%b want 1/1", dk, bk); end
      idle_ok = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (out_valid[1] !== 1'b0 || busy[1] !== 1'b0) idle_ok = 0;
      end
      total++; if (!idle_ok) begin bad++; $display("FAIL gap_after_byte3 got activity want idle"); end
   endtask

   task automatic test_encoding;
      int          xs [6] = '{300, 255, 256, 511, 0, -1};
      int          ys [6] = '{-300, -256, -257, -512, -1, 1};
      logic [7:0]  got [3];
      int          gap [2];
      int          cyc;
      bit          dk, bk, hk, tmo;
      logic [23:0] e;
      logic [2:0]  b;
      for (int i = 0; i < 6; i++) begin
         b = (i == 0) ? 3'b000 : 3'($urandom);
         e = model_pkt(b, xs[i], ys[i]);
         xfer(0, b, xs[i], ys[i], 100, 0, got, gap, cyc, dk, bk, hk, tmo);
         exp_count[0]++;
         total++;
         if (tmo || {got[0], got[1], got[2]} !== e) begin
            bad++; $display("FAIL enc_dx%0d_dy%0d got %h%h%h want %h", xs[i], ys[i], got[0], got[1], got[2], e);
         end
      end
   endtask

   task automatic test_random;
      logic [7:0]  got [3];
      int          gap [2];
      int          cyc;
      bit          dk, bk, hk, tmo;
      logic [23:0] e;
      logic [2:0]  b;
      int          u, x, y, eg;
      for (int i = 0; i < 40; i++) begin
         u = int'($urandom_range(0, 1));
         b = 3'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            x = int'($urandom_range(0, 1023)) - 512; y = int'($urandom_range(0, 1023)) - 512;
         end else begin
            x = int'($urandom_range(0, 40)) - 20; y = int'($urandom_range(0, 40)) - 20;
         end
         e  = model_pkt(b, x, y);
         eg = (u == 1) ? 3 : 0;
         xfer(u, b, x, y, 60, 0, got, gap, cyc, dk, bk, hk, tmo);
         exp_count[u]++;
         total++;
         if (tmo || {got[0], got[1], got[2]} !== e || gap[0] !== eg || gap[1] !== eg ||
             !dk || !bk || !hk || pkt_count[u] !== 16'(exp_count[u])) begin
            bad++;
            $display("FAIL rand%0d dut%0d got %h%h%h gaps %0d/%0d cnt %0d flags %b%b%b%b want %h gaps %0d cnt %0d",
                     i, u, got[0], got[1], got[2], gap[0], gap[1], pkt_count[u], tmo, dk, bk, hk, e, eg, exp_count[u]);
         end
      end
   endtask

   task automatic test_reset_gap;
      bit quiet;
      total++; if (pkt_count[1] !== 16'(exp_count[1])) begin bad++; $display("FAIL rgap_precount got %0d want %0d", pkt_count[1], exp_count[1]); end
      pkt_valid[1] = 1'b1; btn[1] = 3'b101; dx[1] = MW'(17); dy[1] = MW'(-9); out_ready[1] = 1'b1;
      @(negedge clk);
      pkt_valid[1] = 1'b0;
      @(negedge clk);
      total++; if (out_valid[1] !== 1'b0 || busy[1] !== 1'b1) begin bad++; $display("FAIL rgap_in_gap got v=%b busy=%b want v=0 busy=1", out_valid[1], busy[1]); end
      reset_n[1] = 1'b0;
      #1;
      exp_count[1] = 0;
      total++;
      if ({pkt_ready[1], out_valid[1], out_data[1], done[1], busy[1], pkt_count[1]} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000}) begin
         bad++; $display("FAIL rgap_async got rdy=%b v=%b d=%h done=%b busy=%b cnt=%0d want 1 0 00 0 0 0",
                         pkt_ready[1], out_valid[1], out_data[1], done[1], busy[1], pkt_count[1]);
      end
      @(negedge clk);
      reset_n[1] = 1'b1;
      quiet = 1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done[1] !== 1'b0 || out_valid[1] !== 1'b0 || pkt_count[1] !== 16'd0) quiet = 0;
      end
      total++; if (!quiet) begin bad++; $display("FAIL rgap_abort got activity after reset want none, cnt=%0d", pkt_count[1]); end
   endtask

   task automatic test_wrap;
      logic [7:0] got [3];
      int         gap [2];
      int         cyc;
      bit         dk, bk, hk, tmo;
      force u_dut0.r_pkt_count = 16'hFFFF;
      #1;
      release u_dut0.r_pkt_count;
      @(negedge clk);
      total++; if (pkt_count[0] !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got %h want ffff", pkt_count[0]); end
      xfer(0, 3'b010, 1, 1, 100, 0, got, gap, cyc, dk, bk, hk, tmo);
      exp_count[0] = 0;
      total++; if (tmo || pkt_count[0] !== 16'h0000) begin bad++; $display("FAIL wrap_count got %h want 0000", pkt_count[0]); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_back_to_back();
      test_gap();
      test_encoding();
      test_random();
      test_reset_gap();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
